// File: rtl/mst_pref_buf_if.sv
// Prefetch buffer bus: consumer read port plus the fetch-side links to the
// internal FIFO and the streaming generators.
interface mst_pref_buf_if #(
    parameter int WIDTH = 36,
    parameter int NCHN  = 4,
    parameter int DEPTH = 4
);
    localparam int CHNBIT  = $clog2(NCHN);
    localparam int ADDRBIT = $clog2(DEPTH);

    // control and consumer side
    logic                     prefena;
    logic [NCHN-1:0]          prefmod;
    logic [NCHN-1:0]          flush;
    logic [CHNBIT-1:0]        rdchn;
    logic                     prefreq;
    logic [NCHN-1:0]          prefnempt;
    logic [WIDTH-1:0]         prefdout;
    logic [ADDRBIT:0]         prefcnt;

    // fetch side
    logic                     ififord;
    logic [CHNBIT-1:0]        ififochn;
    logic [NCHN-1:0]          ifnempt;
    logic [WIDTH-1:0]         ififodat;
    logic [NCHN-1:0]          genreq;
    logic [NCHN*(WIDTH-4)-1:0] gendat;

    logic                     ovf_err;

    // buffer side
    modport slave (
        input  prefena, prefmod, flush, rdchn, prefreq, ifnempt, ififodat, gendat,
        output prefnempt, prefdout, prefcnt, ififord, ififochn, genreq, ovf_err
    );

    // environment side (consumer, FIFO and generators)
    modport master (
        output prefena, prefmod, flush, rdchn, prefreq, ifnempt, ififodat, gendat,
        input  prefnempt, prefdout, prefcnt, ififord, ififochn, genreq, ovf_err
    );
endinterface

// File: rtl/mst_pref_buf.sv
// Multi-channel prefetch buffer. Each channel keeps a small circular buffer
// topped up (to WMARK words) from either the shared internal FIFO or its own
// streaming generator, one fetch per cycle chosen round-robin. The consumer
// sees the head of the selected channel first-word-fall-through.
module mst_pref_buf #(
    parameter int WIDTH = 36,
    parameter int NCHN  = 4,
    parameter int DEPTH = 4,
    parameter int WMARK = DEPTH - 1
) (
    input  logic          clk,
    input  logic          rst,
    mst_pref_buf_if.slave bus
);
    localparam int CHNBIT  = $clog2(NCHN);
    localparam int ADDRBIT = $clog2(DEPTH);
    localparam int GW      = WIDTH - 4;

    typedef logic [CHNBIT-1:0]  chn_t;
    typedef logic [ADDRBIT-1:0] ptr_t;
    typedef logic [ADDRBIT:0]   len_t;
    typedef logic [ADDRBIT+1:0] lvl_t;

    localparam len_t LEN_FULL = len_t'(DEPTH);
    localparam lvl_t LVL_MARK = lvl_t'(WMARK);

    // storage and per-channel state
    logic [WIDTH-1:0] mem   [NCHN][DEPTH];
    ptr_t             wrptr [NCHN];
    ptr_t             rdptr [NCHN];
    len_t             len   [NCHN];
    logic [NCHN-1:0]  pend;

    // arbiter and registered grant
    chn_t             rrptr;
    chn_t             gnt_chn;
    logic             gnt_mod;
    logic             ovf_err_q;

    // combinational helpers
    logic [NCHN-1:0]  elig;
    logic             gnt_vld;
    chn_t             gnt_idx;
    chn_t             cand;
    logic [NCHN-1:0]  gnt_oh;
    logic [NCHN-1:0]  pop;
    logic [NCHN-1:0]  wr_ok;
    logic [NCHN-1:0]  wr_ovf;
    logic             udf;
    logic [WIDTH-1:0] wr_data;

    // A channel may fetch while its committed level (stored plus in flight)
    // is below the watermark and its source has something to give.
    always_comb begin
        for (int unsigned c = 0; c < NCHN; c++) begin
            elig[c] = !rst && bus.prefena && !bus.flush[c]
                   && (({1'b0, len[c]} + lvl_t'(pend[c])) < LVL_MARK)
                   && (bus.prefmod[c] || bus.ifnempt[c]);
        end
    end

    // Round-robin search starting one past the last granted channel; the
    // last candidate wraps back to rrptr itself.
    always_comb begin
        gnt_vld = 1'b0;
        gnt_idx = rrptr;
        cand    = rrptr;
        for (int unsigned i = 1; i <= NCHN; i++) begin
            cand = rrptr + chn_t'(i);
            if (!gnt_vld && elig[cand]) begin
                gnt_vld = 1'b1;
                gnt_idx = cand;
            end
        end
    end

    // Fetch strobes: FIFO read or generator request depending on live mode.
    always_comb begin
        gnt_oh       = '0;
        bus.genreq   = '0;
        bus.ififord  = 1'b0;
        bus.ififochn = gnt_idx;
        if (gnt_vld) begin
            gnt_oh[gnt_idx] = 1'b1;
            if (bus.prefmod[gnt_idx]) begin
                bus.genreq[gnt_idx] = 1'b1;
            end else begin
                bus.ififord = 1'b1;
            end
        end
    end

    // Consumer view of the selected channel.
    always_comb begin
        for (int unsigned c = 0; c < NCHN; c++) begin
            bus.prefnempt[c] = (len[c] != '0);
        end
        bus.prefcnt  = len[bus.rdchn];
        bus.prefdout = mem[bus.rdchn][rdptr[bus.rdchn]];
    end

    // Pop, landing-write and error qualification. A flushed channel neither
    // pops nor accepts its landing word; a full channel only accepts the
    // word if a pop frees a slot in the same cycle.
    always_comb begin
        pop = '0;
        udf = 1'b0;
        if (bus.prefreq && !bus.flush[bus.rdchn]) begin
            if (len[bus.rdchn] != '0) begin
                pop[bus.rdchn] = 1'b1;
            end else begin
                udf = 1'b1;
            end
        end
        wr_data = gnt_mod ? {4'hF, bus.gendat[int'(gnt_chn) * GW +: GW]} : bus.ififodat;
        for (int unsigned c = 0; c < NCHN; c++) begin
            wr_ok[c]  = pend[c] && !bus.flush[c] && ((len[c] != LEN_FULL) || pop[c]);
            wr_ovf[c] = pend[c] && !bus.flush[c] && (len[c] == LEN_FULL) && !pop[c];
        end
    end

    // Channel pointers, lengths, in-flight tracking, arbiter state and error.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int unsigned c = 0; c < NCHN; c++) begin
                wrptr[c] <= '0;
                rdptr[c] <= '0;
                len[c]   <= '0;
            end
            pend      <= '0;
            rrptr     <= chn_t'(NCHN - 1);
            gnt_chn   <= '0;
            gnt_mod   <= 1'b0;
            ovf_err_q <= 1'b0;
        end else begin
            for (int unsigned c = 0; c < NCHN; c++) begin
                if (bus.flush[c]) begin
                    wrptr[c] <= '0;
                    rdptr[c] <= '0;
                    len[c]   <= '0;
                end else begin
                    if (wr_ok[c]) begin
                        wrptr[c] <= wrptr[c] + 1'b1;
                    end
                    if (pop[c]) begin
                        rdptr[c] <= rdptr[c] + 1'b1;
                    end
                    if (wr_ok[c] && !pop[c]) begin
                        len[c] <= len[c] + 1'b1;
                    end else if (!wr_ok[c] && pop[c]) begin
                        len[c] <= len[c] - 1'b1;
                    end
                end
            end
            pend <= gnt_oh & ~bus.flush;
            if (gnt_vld) begin
                rrptr   <= gnt_idx;
                gnt_chn <= gnt_idx;
                gnt_mod <= bus.prefmod[gnt_idx];
            end
            if (udf || (wr_ovf != '0)) begin
                ovf_err_q <= 1'b1;
            end
        end
    end

    // Buffer storage; contents are don't-care until written.
    always_ff @(posedge clk) begin
        for (int unsigned c = 0; c < NCHN; c++) begin
            if (wr_ok[c]) begin
                mem[c][wrptr[c]] <= wr_data;
            end
        end
    end

    assign bus.ovf_err = ovf_err_q;

endmodule

// File: tb/tb_mst_pref_buf.sv
// Bench for mst_pref_buf: per-channel data scoreboard fed by the responder
// that answers fetch strobes, a round-robin vector table, and directed
// sequences for fill, tagging, pop+write, flush, underflow and reset.
module tb_mst_pref_buf;
    localparam int WIDTH = 36;
    localparam int NCHN  = 4;
    localparam int DEPTH = 4;
    localparam int WMARK = 3;
    localparam int GW    = WIDTH - 4;

    typedef logic [WIDTH-1:0] word_t;

    typedef struct {
        logic [NCHN-1:0] ifn;
        logic [NCHN-1:0] mod;
        logic            rd;
        logic [NCHN-1:0] gen;
        logic [1:0]      chn;
    } vec_t;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    mst_pref_buf_if #(.WIDTH(WIDTH), .NCHN(NCHN), .DEPTH(DEPTH)) bus ();

    mst_pref_buf #(.WIDTH(WIDTH), .NCHN(NCHN), .DEPTH(DEPTH), .WMARK(WMARK)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int          checks = 0;
    int          errors = 0;
    word_t       sb [NCHN][$];
    logic        exp_err;
    logic        rq_v, rq_mod, lnd_v;
    int          rq_chn, lnd_chn;
    word_t       lnd_word;
    logic        fix_en;
    logic [GW-1:0] fix_val;
    int          npop;
    int          seq;
    vec_t        vt [14];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: actual %0h required %0h", nm, act, exp);
        end
    endtask

    task automatic clear_model();
        for (int c = 0; c < NCHN; c++) sb[c].delete();
        exp_err = 1'b0;
        rq_v    = 1'b0;
        lnd_v   = 1'b0;
    endtask

    // One clock: check state against the model at the falling edge, retire
    // pops and landing words, capture new fetch requests, then answer them
    // with data just after the rising edge.
    task automatic cyc();
        logic [NCHN-1:0] exp_ne;
        logic [GW-1:0]   g;
        int              rc;
        @(negedge clk);
        rc = int'(bus.rdchn);
        for (int c = 0; c < NCHN; c++) exp_ne[c] = (sb[c].size() != 0);
        chk("nempt", bus.prefnempt, exp_ne);
        chk("cnt", bus.prefcnt, sb[rc].size());
        chk("ovf_err", bus.ovf_err, exp_err);
        if (sb[rc].size() != 0) chk("head", bus.prefdout, sb[rc][0]);
        if (bus.prefreq && !bus.flush[rc]) begin
            if (sb[rc].size() != 0) begin
                void'(sb[rc].pop_front());
                npop++;
            end else begin
                exp_err = 1'b1;
            end
        end
        if (lnd_v && !bus.flush[lnd_chn]) sb[lnd_chn].push_back(lnd_word);
        for (int c = 0; c < NCHN; c++) if (bus.flush[c]) sb[c].delete();
        rq_v = 1'b0;
        if (bus.ififord) begin
            rq_v   = 1'b1;
            rq_chn = int'(bus.ififochn);
            rq_mod = 1'b0;
        end
        for (int c = 0; c < NCHN; c++) begin
            if (bus.genreq[c]) begin
                rq_v   = 1'b1;
                rq_chn = c;
                rq_mod = 1'b1;
            end
        end
        @(posedge clk);
        #1;
        for (int c = 0; c < NCHN; c++) bus.gendat[c*GW +: GW] = GW'($urandom);
        bus.ififodat = {4'($urandom), 32'($urandom)};
        lnd_v   = rq_v;
        lnd_chn = rq_chn;
        if (rq_v) begin
            if (rq_mod) begin
                g = fix_en ? fix_val : GW'($urandom);
                bus.gendat[rq_chn*GW +: GW] = g;
                lnd_word = {4'hF, g};
            end else begin
                bus.ififodat = {4'(seq), 32'($urandom)};
                lnd_word = bus.ififodat;
                seq++;
            end
        end
    endtask

    // Reset with fetch pressure present, to show strobes stay low in reset.
    task automatic do_reset();
        rst          = 1'b1;
        bus.prefena  = 1'b1;
        bus.prefmod  = 4'b1010;
        bus.ifnempt  = '1;
        bus.flush    = '0;
        bus.rdchn    = '0;
        bus.prefreq  = 1'b1;
        bus.ififodat = '0;
        bus.gendat   = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_nempt", bus.prefnempt, 0);
        chk("rst_cnt", bus.prefcnt, 0);
        chk("rst_ififord", bus.ififord, 0);
        chk("rst_genreq", bus.genreq, 0);
        chk("rst_ovf", bus.ovf_err, 0);
        clear_model();
        @(posedge clk);
        #1;
        rst         = 1'b0;
        bus.prefena = 1'b0;
        bus.prefmod = '0;
        bus.ifnempt = '0;
        bus.prefreq = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: actual timeout required finish");
        $fatal(1);
    end

    initial begin
        fix_en = 1'b0;
        fix_val = '0;
        npop = 0;
        seq = 0;

        // round-robin table: channel 2 streams, the others read the FIFO
        for (int i = 0; i < 14; i++) begin
            vt[i].ifn = 4'b1011;
            vt[i].mod = 4'b0100;
            if (i < 12) begin
                vt[i].chn = 2'(i % 4);
                vt[i].rd  = (i % 4) != 2;
                vt[i].gen = ((i % 4) == 2) ? 4'b0100 : 4'b0000;
            end else begin
                vt[i].chn = 2'd3;
                vt[i].rd  = 1'b0;
                vt[i].gen = 4'b0000;
            end
        end

        // loop-back fill of a single channel up to the watermark
        do_reset();
        bus.ifnempt = 4'b0001;
        bus.prefena = 1'b1;
        for (int k = 0; k < 6; k++) begin
            #1;
            chk("fill_rd", bus.ififord, (k < 3) ? 1 : 0);
            if (k < 3) chk("fill_chn", bus.ififochn, 0);
            cyc();
        end
        chk("fill_len", bus.prefcnt, 3);
        bus.prefena = 1'b0;
        bus.prefreq = 1'b1;
        repeat (3) cyc();
        bus.prefreq = 1'b0;
        cyc();

        // round-robin arbitration from reset
        do_reset();
        bus.prefena = 1'b1;
        for (int i = 0; i < 14; i++) begin
            bus.ifnempt = vt[i].ifn;
            bus.prefmod = vt[i].mod;
            #1;
            chk("rr_rd", bus.ififord, vt[i].rd);
            chk("rr_gen", bus.genreq, vt[i].gen);
            chk("rr_chn", bus.ififochn, vt[i].chn);
            cyc();
        end
        bus.prefena = 1'b0;
        for (int c = 0; c < NCHN; c++) begin
            bus.rdchn = 2'(c);
            #1;
            chk("rr_len", bus.prefcnt, 3);
            bus.prefreq = 1'b1;
            repeat (3) cyc();
            bus.prefreq = 1'b0;
        end
        cyc();

        // streaming tag on channel 2
        do_reset();
        bus.prefmod = 4'b0100;
        bus.prefena = 1'b1;
        fix_en = 1'b1;
        fix_val = 32'h12345678;
        #1;
        chk("tag_genreq", bus.genreq, 4'b0100);
        chk("tag_ififord", bus.ififord, 0);
        chk("tag_chn", bus.ififochn, 2);
        cyc();
        bus.prefena = 1'b0;
        cyc();
        bus.rdchn = 2'd2;
        #1;
        chk("tag_dout", bus.prefdout, 36'hF12345678);
        chk("tag_len", bus.prefcnt, 1);
        bus.prefreq = 1'b1;
        cyc();
        bus.prefreq = 1'b0;
        fix_en = 1'b0;
        cyc();

        // simultaneous pop and write on channel 0, across pointer wrap
        do_reset();
        bus.ifnempt = 4'b0001;
        bus.prefena = 1'b1;
        repeat (3) cyc();
        bus.prefreq = 1'b1;
        #1;
        chk("pw_len_before", bus.prefcnt, 2);
        npop = 0;
        cyc();
        #1;
        chk("pw_len_after", bus.prefcnt, 2);
        for (int k = 0; k < 60 && npop < 10; k++) cyc();
        chk("pw_npop", (npop >= 10) ? 1 : 0, 1);

        // reset mid-transfer, then flush with a word landing
        do_reset();
        bus.ifnempt = 4'b0010;
        bus.prefena = 1'b1;
        bus.rdchn = 2'd1;
        #1;
        chk("fl_rd", bus.ififord, 1);
        chk("fl_chn", bus.ififochn, 1);
        cyc();
        bus.flush = 4'b0010;
        bus.prefena = 1'b0;
        cyc();
        bus.flush = '0;
        #1;
        chk("fl_len", bus.prefcnt, 0);
        chk("fl_nempt", bus.prefnempt, 0);
        chk("fl_ovf", bus.ovf_err, 0);
        cyc();

        // underflow on an empty channel, then normal traffic on it
        bus.rdchn = 2'd3;
        bus.prefreq = 1'b1;
        cyc();
        bus.prefreq = 1'b0;
        #1;
        chk("udf_ovf", bus.ovf_err, 1);
        chk("udf_cnt", bus.prefcnt, 0);
        bus.ifnempt = 4'b1000;
        bus.prefena = 1'b1;
        repeat (4) cyc();
        bus.prefena = 1'b0;
        bus.prefreq = 1'b1;
        repeat (3) cyc();
        bus.prefreq = 1'b0;
        repeat (3) cyc();
        chk("udf_sticky", bus.ovf_err, 1);

        // mixed random traffic; underflow avoided so the error stays clear
        do_reset();
        for (int k = 0; k < 400; k++) begin
            bus.prefena = ($urandom_range(0, 4) != 0);
            bus.prefmod = 4'($urandom);
            bus.ifnempt = 4'($urandom);
            bus.flush   = ($urandom_range(0, 11) == 0) ? 4'($urandom) : 4'b0000;
            bus.rdchn   = 2'($urandom);
            bus.prefreq = (sb[int'(bus.rdchn)].size() != 0) && ($urandom_range(0, 1) != 0);
            cyc();
        end
        bus.prefena = 1'b0;
        bus.prefreq = 1'b0;
        bus.flush = '0;
        cyc();
        do_reset();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
